// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, the imem read handshake, the IF/ID
// register and a direct-mapped BTB of 2-bit counters for next-PC prediction.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0060,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] instr_IFID,
    output logic [31:0] pc_addr_IFID,
    output logic        taken_IFID
);
    localparam int          IDX_W = $clog2(BTB_ENTRIES);
    localparam int          TAG_W = 32 - IDX_W - 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pending_pc_reg;
    logic [31:0] skid_instr_reg;
    logic [31:0] skid_pc_reg;
    logic [31:0] skid_next_reg;
    logic        skid_pred_reg;

    logic [BTB_ENTRIES-1:0] btb_valid_reg;
    logic [TAG_W-1:0]       btb_tag_reg    [BTB_ENTRIES];
    logic [31:0]            btb_target_reg [BTB_ENTRIES];
    logic [1:0]             btb_ctr_reg    [BTB_ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             pred_taken;
    logic             upd_hit;
    logic [31:0]      next_pc;
    logic             unused_ok;

    assign fetch_idx = pc_reg[IDX_W+1:2];
    assign fetch_tag = pc_reg[31:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign unused_ok = ^upd_pc[1:0];

    // Lookup sees the table as it was before any same-edge update.
    assign pred_taken = btb_valid_reg[fetch_idx] && (btb_tag_reg[fetch_idx] == fetch_tag)
                        && btb_ctr_reg[fetch_idx][1];
    assign next_pc    = pred_taken ? btb_target_reg[fetch_idx] : pc_reg + 32'd4;
    assign upd_hit    = btb_valid_reg[upd_idx] && (btb_tag_reg[upd_idx] == upd_tag);

    // DRAIN keeps the old address on the bus; only HOLD drops the request.
    assign imem_read    = (state_reg != HOLD);
    assign imem_address = {pc_reg[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_reg <= '0;
        end else if (upd_valid && !upd_hit && upd_taken) begin
            btb_valid_reg[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (btb_ctr_reg[upd_idx] != 2'b11)
                        btb_ctr_reg[upd_idx] <= btb_ctr_reg[upd_idx] + 2'd1;
                    btb_target_reg[upd_idx] <= upd_target;
                end else if (btb_ctr_reg[upd_idx] != 2'b00) begin
                    btb_ctr_reg[upd_idx] <= btb_ctr_reg[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_tag_reg[upd_idx]    <= upd_tag;
                btb_target_reg[upd_idx] <= upd_target;
                btb_ctr_reg[upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= REQ;
            pc_reg         <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            skid_instr_reg <= NOP;
            skid_pc_reg    <= '0;
            skid_next_reg  <= RESET_PC;
            skid_pred_reg  <= 1'b0;
            instr_IFID     <= NOP;
            pc_addr_IFID   <= '0;
            taken_IFID     <= 1'b0;
        end else if (redirect) begin
            instr_IFID   <= NOP;
            pc_addr_IFID <= '0;
            taken_IFID   <= 1'b0;
            // An unanswered request must be drained before the new PC goes out.
            if ((state_reg == REQ || state_reg == DRAIN) && !imem_resp) begin
                pending_pc_reg <= redirect_pc;
                state_reg      <= DRAIN;
            end else begin
                pc_reg    <= redirect_pc;
                state_reg <= REQ;
            end
        end else begin
            case (state_reg)
                REQ: begin
                    if (imem_resp && !stall) begin
                        instr_IFID   <= imem_rdata;
                        pc_addr_IFID <= pc_reg;
                        taken_IFID   <= pred_taken;
                        pc_reg       <= next_pc;
                    end else if (imem_resp) begin
                        skid_instr_reg <= imem_rdata;
                        skid_pc_reg    <= pc_reg;
                        skid_pred_reg  <= pred_taken;
                        skid_next_reg  <= next_pc;
                        state_reg      <= HOLD;
                    end else if (!stall) begin
                        instr_IFID   <= NOP;
                        pc_addr_IFID <= '0;
                        taken_IFID   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_IFID   <= skid_instr_reg;
                        pc_addr_IFID <= skid_pc_reg;
                        taken_IFID   <= skid_pred_reg;
                        pc_reg       <= skid_next_reg;
                        state_reg    <= REQ;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        instr_IFID   <= NOP;
                        pc_addr_IFID <= '0;
                        taken_IFID   <= 1'b0;
                    end
                    if (imem_resp) begin
                        pc_reg    <= pending_pc_reg;
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch sequencing, stall/skid, BTB prediction,
// redirect drain, redirect+stall and asynchronous reset during HOLD.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst, stall, redirect, upd_valid, upd_taken, imem_resp;
    logic [31:0] redirect_pc, upd_pc, upd_target, imem_rdata;
    logic        imem_read, taken_IFID;
    logic [31:0] imem_address, instr_IFID, pc_addr_IFID;

    int vectors = 0;
    int miscompares = 0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .imem_read(imem_read), .imem_address(imem_address), .imem_rdata(imem_rdata),
        .imem_resp(imem_resp), .instr_IFID(instr_IFID), .pc_addr_IFID(pc_addr_IFID),
        .taken_IFID(taken_IFID)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        imem_resp = 1'b0; imem_rdata = 32'h13;
        #2;
        vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp %h", pc_addr_IFID, 32'h0); end
        vectors++; if (instr_IFID !== 32'h13) begin miscompares++; $display("FAIL reset_instr got %h exp %h", instr_IFID, 32'h13); end
        vectors++; if (taken_IFID !== 1'b0) begin miscompares++; $display("FAIL reset_taken got %b exp 0", taken_IFID); end
        vectors++; if (imem_address !== 32'h60) begin miscompares++; $display("FAIL reset_addr got %h exp %h", imem_address, 32'h60); end
        vectors++; if (imem_read !== 1'b1) begin miscompares++; $display("FAIL reset_read got %b exp 1", imem_read); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        imem_resp = 1'b1; imem_rdata = 32'h13;
        step();
        vectors++; if (imem_address !== 32'h64) begin miscompares++; $display("FAIL fetch_addr1 got %h exp %h", imem_address, 32'h64); end
        vectors++; if (pc_addr_IFID !== 32'h60) begin miscompares++; $display("FAIL fetch_pc1 got %h exp %h", pc_addr_IFID, 32'h60); end
        vectors++; if (taken_IFID !== 1'b0) begin miscompares++; $display("FAIL fetch_taken1 got %b exp 0", taken_IFID); end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h0040_0093;
        step();
        imem_resp = 1'b0;
        vectors++; if (pc_addr_IFID !== 32'h60) begin miscompares++; $display("FAIL stall_hold1 got %h exp %h", pc_addr_IFID, 32'h60); end
        vectors++; if (imem_read !== 1'b0) begin miscompares++; $display("FAIL stall_read1 got %b exp 0", imem_read); end
        step();
        vectors++; if (pc_addr_IFID !== 32'h60) begin miscompares++; $display("FAIL stall_hold2 got %h exp %h", pc_addr_IFID, 32'h60); end
        vectors++; if (imem_read !== 1'b0) begin miscompares++; $display("FAIL stall_read2 got %b exp 0", imem_read); end
        step();
        stall = 1'b0;
        step();
        vectors++; if (pc_addr_IFID !== 32'h64) begin miscompares++; $display("FAIL stall_release_pc got %h exp %h", pc_addr_IFID, 32'h64); end
        vectors++; if (instr_IFID !== 32'h0040_0093) begin miscompares++; $display("FAIL stall_release_instr got %h exp %h", instr_IFID, 32'h0040_0093); end
        vectors++; if (imem_address !== 32'h68) begin miscompares++; $display("FAIL stall_release_addr got %h exp %h", imem_address, 32'h68); end
        vectors++; if (imem_read !== 1'b1) begin miscompares++; $display("FAIL stall_release_read got %b exp 1", imem_read); end
    endtask

    task automatic test_btb();
        imem_resp = 1'b1; imem_rdata = 32'h13;
        upd_valid = 1'b1; upd_pc = 32'h70; upd_taken = 1'b1; upd_target = 32'h100;
        step();
        upd_valid = 1'b0;
        step();
        vectors++; if (imem_address !== 32'h70) begin miscompares++; $display("FAIL btb_reach70 got %h exp %h", imem_address, 32'h70); end
        step();
        vectors++; if (imem_address !== 32'h100) begin miscompares++; $display("FAIL btb_target got %h exp %h", imem_address, 32'h100); end
        vectors++; if (pc_addr_IFID !== 32'h70) begin miscompares++; $display("FAIL btb_pc got %h exp %h", pc_addr_IFID, 32'h70); end
        vectors++; if (taken_IFID !== 1'b1) begin miscompares++; $display("FAIL btb_taken got %b exp 1", taken_IFID); end
        imem_resp = 1'b0;
        upd_valid = 1'b1; upd_taken = 1'b0;
        step();
        vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL noresp_bubble got %h exp %h", pc_addr_IFID, 32'h0); end
        vectors++; if (imem_address !== 32'h100) begin miscompares++; $display("FAIL noresp_addr got %h exp %h", imem_address, 32'h100); end
        step();
        upd_valid = 1'b0;
        imem_resp = 1'b1; redirect = 1'b1; redirect_pc = 32'h70;
        step();
        redirect = 1'b0;
        vectors++; if (imem_address !== 32'h70) begin miscompares++; $display("FAIL btb_redirect_addr got %h exp %h", imem_address, 32'h70); end
        vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL btb_redirect_bubble got %h exp %h", pc_addr_IFID, 32'h0); end
        step();
        vectors++; if (imem_address !== 32'h74) begin miscompares++; $display("FAIL btb_untrained_addr got %h exp %h", imem_address, 32'h74); end
        vectors++; if (taken_IFID !== 1'b0) begin miscompares++; $display("FAIL btb_untrained_taken got %b exp 0", taken_IFID); end
        vectors++; if (pc_addr_IFID !== 32'h70) begin miscompares++; $display("FAIL btb_untrained_pc got %h exp %h", pc_addr_IFID, 32'h70); end
    endtask

    task automatic test_redirect_drain();
        for (int i = 0; i < 3; i++) step();
        vectors++; if (imem_address !== 32'h80) begin miscompares++; $display("FAIL drain_pre_addr got %h exp %h", imem_address, 32'h80); end
        imem_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (imem_address !== 32'h80) begin miscompares++; $display("FAIL drain_addr%0d got %h exp %h", i, imem_address, 32'h80); end
            vectors++; if (imem_read !== 1'b1) begin miscompares++; $display("FAIL drain_read%0d got %b exp 1", i, imem_read); end
            vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL drain_bubble%0d got %h exp %h", i, pc_addr_IFID, 32'h0); end
            step();
        end
        vectors++; if (imem_address !== 32'h80) begin miscompares++; $display("FAIL drain_addr2 got %h exp %h", imem_address, 32'h80); end
        imem_resp = 1'b1; imem_rdata = 32'hdead_beef;
        step();
        vectors++; if (imem_address !== 32'h200) begin miscompares++; $display("FAIL drain_next_addr got %h exp %h", imem_address, 32'h200); end
        vectors++; if (instr_IFID !== 32'h13) begin miscompares++; $display("FAIL drain_discard got %h exp %h", instr_IFID, 32'h13); end
        imem_rdata = 32'h13;
        step();
        vectors++; if (pc_addr_IFID !== 32'h200) begin miscompares++; $display("FAIL drain_first_pc got %h exp %h", pc_addr_IFID, 32'h200); end
    endtask

    task automatic test_redirect_stall();
        imem_resp = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0; stall = 1'b0;
        vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL rs_bubble got %h exp %h", pc_addr_IFID, 32'h0); end
        vectors++; if (imem_address !== 32'h300) begin miscompares++; $display("FAIL rs_addr got %h exp %h", imem_address, 32'h300); end
        step();
        vectors++; if (pc_addr_IFID !== 32'h300) begin miscompares++; $display("FAIL rs_resume_pc got %h exp %h", pc_addr_IFID, 32'h300); end
        vectors++; if (imem_address !== 32'h304) begin miscompares++; $display("FAIL rs_resume_addr got %h exp %h", imem_address, 32'h304); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; imem_resp = 1'b1;
        step();
        imem_resp = 1'b0;
        vectors++; if (imem_read !== 1'b0) begin miscompares++; $display("FAIL ar_in_hold got %b exp 0", imem_read); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (imem_address !== 32'h60) begin miscompares++; $display("FAIL ar_addr got %h exp %h", imem_address, 32'h60); end
        vectors++; if (pc_addr_IFID !== 32'h0) begin miscompares++; $display("FAIL ar_pc got %h exp %h", pc_addr_IFID, 32'h0); end
        vectors++; if (instr_IFID !== 32'h13) begin miscompares++; $display("FAIL ar_instr got %h exp %h", instr_IFID, 32'h13); end
        vectors++; if (imem_read !== 1'b1) begin miscompares++; $display("FAIL ar_read got %b exp 1", imem_read); end
        #1 rst = 1'b0;
        stall = 1'b0; imem_resp = 1'b1;
        step();
        vectors++; if (pc_addr_IFID !== 32'h60) begin miscompares++; $display("FAIL ar_restart_pc got %h exp %h", pc_addr_IFID, 32'h60); end
        vectors++; if (imem_address !== 32'h64) begin miscompares++; $display("FAIL ar_restart_addr got %h exp %h", imem_address, 32'h64); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_btb();
        test_redirect_drain();
        test_redirect_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
